// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared button FSM state encoding and default timing constants
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } btn_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_LONG_CYCLES     = 50_000_000;
    localparam int DEFAULT_CNT_W           = 32;

endpackage

// File: rtl/btn_debounce_fsm.sv
// rtl/btn_debounce_fsm.sv - one button: 2-flop synchroniser, debounce FSM, press/release/long pulses
// Long-press tracking present only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_fsm
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic press_next
);

    localparam logic [1:0] S_RELEASED   = RELEASED;
    localparam logic [1:0] S_PRESS_PEND = PRESS_PEND;
    localparam logic [1:0] S_PRESSED    = PRESSED;
    localparam logic [1:0] S_REL_PEND   = REL_PEND;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    logic long_done;
`else
    logic unused_long_cfg;
    assign unused_long_cfg = ^LONG_CYCLES;
    assign long_pulse      = 1'b0;
`endif

    // Lets the top register chord in the same cycle the press pulse appears.
    assign press_next = !rst && (state == S_PRESS_PEND) && s2 && (cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= S_RELEASED;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            long_done     <= 1'b0;
            long_pulse    <= 1'b0;
`endif
        end else begin
            s1            <= btn;
            s2            <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            long_pulse    <= 1'b0;
`endif
            case (state)
                S_RELEASED: begin
                    if (s2) begin
                        state <= S_PRESS_PEND;
                        cnt   <= '0;
                    end
                end
                S_PRESS_PEND: begin
                    if (!s2) begin
                        state <= S_RELEASED;
                    end else if (cnt == DEB_LAST) begin
                        state       <= S_PRESSED;
                        press_pulse <= 1'b1;
                        level       <= 1'b1;
                        cnt         <= '0;
`ifdef BTN_LONG_PRESS_EN
                        long_done   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!s2) begin
                        state <= S_REL_PEND;
                        cnt   <= '0;
                    end
`ifdef BTN_LONG_PRESS_EN
                    // Counter freezes once the long event has fired for this hold.
                    else if (!long_done) begin
                        if (cnt == LONG_LAST) begin
                            long_pulse <= 1'b1;
                            long_done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                end
                S_REL_PEND: begin
                    if (s2) begin
                        state <= S_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state         <= S_RELEASED;
                        release_pulse <= 1'b1;
                        level         <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - two debounced buttons plus registered chord detection
// Long-press outputs active only when BTN_LONG_PRESS_EN is defined.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1,
    input  logic btn2,
    output logic btn1_level,
    output logic btn2_level,
    output logic btn1_press,
    output logic btn2_press,
    output logic btn1_release,
    output logic btn2_release,
    output logic btn1_long,
    output logic btn2_long,
    output logic chord
);

    logic btn1_press_next;
    logic btn2_press_next;

    btn_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn1 (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn1),
        .level         (btn1_level),
        .press_pulse   (btn1_press),
        .release_pulse (btn1_release),
        .long_pulse    (btn1_long),
        .press_next    (btn1_press_next)
    );

    btn_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn2 (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn2),
        .level         (btn2_level),
        .press_pulse   (btn2_press),
        .release_pulse (btn2_release),
        .long_pulse    (btn2_long),
        .press_next    (btn2_press_next)
    );

    // A press landing while the other button is held, or both landing together.
    always_ff @(posedge clk) begin
        if (rst) begin
            chord <= 1'b0;
        end else begin
            chord <= (btn1_press_next && (btn2_level || btn2_press_next))
                  || (btn2_press_next && btn1_level);
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder (DEBOUNCE=4, LONG=10)
module tb_button_event_decoder;

    localparam int DEB  = 4;
    localparam int LONG = 10;

    localparam logic [6:0] E_B1P = 7'b0000001;
    localparam logic [6:0] E_B1R = 7'b0000010;
    localparam logic [6:0] E_B1L = 7'b0000100;
    localparam logic [6:0] E_B2P = 7'b0001000;
    localparam logic [6:0] E_B2R = 7'b0010000;
    localparam logic [6:0] E_B2L = 7'b0100000;
    localparam logic [6:0] E_CH  = 7'b1000000;

    typedef struct {
        int         cyc;
        logic [6:0] ev;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn1 = 1'b0;
    logic btn2 = 1'b0;
    logic btn1_level, btn2_level, btn1_press, btn2_press;
    logic btn1_release, btn2_release, btn1_long, btn2_long, chord;
    logic [6:0] ev;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    button_event_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .CNT_W           (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn1         (btn1),
        .btn2         (btn2),
        .btn1_level   (btn1_level),
        .btn2_level   (btn2_level),
        .btn1_press   (btn1_press),
        .btn2_press   (btn2_press),
        .btn1_release (btn1_release),
        .btn2_release (btn2_release),
        .btn1_long    (btn1_long),
        .btn2_long    (btn2_long),
        .chord        (chord)
    );

    assign ev = {chord, btn2_long, btn2_release, btn2_press, btn1_long, btn1_release, btn1_press};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_ev(int c, logic [6:0] v);
        q.push_back('{c, v});
    endfunction

    task automatic go(int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle with a scheduled or observed event is compared.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL missing_event: expected %07b at cycle %0d, not seen", q[0].ev, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("event_vector", 32'(ev), 32'(q[0].ev));
            void'(q.pop_front());
        end else if (ev !== 7'b0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event at cycle %0d: got %07b expected 0000000", cyc, ev);
        end
    end

    initial begin
        // Reset held over edges 1..3.
        go(3);
        chk("reset_outputs", 32'({ev, btn1_level, btn2_level}), 32'd0);
        rst = 1'b0;

        // Clean press first sampled at edge 10 -> press after edge 16.
        go(9);
        btn1 = 1'b1;
        expect_ev(16, E_B1P);
`ifdef BTN_LONG_PRESS_EN
        expect_ev(26, E_B1L);
`endif
        go(17);
        chk("b1_level_after_press", 32'(btn1_level), 32'd1);
        go(29);
        btn1 = 1'b0;
        expect_ev(36, E_B1R);
        go(37);
        chk("b1_level_after_release", 32'(btn1_level), 32'd0);

        // Bounce: three-cycle high pulse, then 2-cycle toggling.
        go(40);
        btn1 = 1'b1;
        go(43);
        btn1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            go(50 + 2 * i);
            btn1 = ~btn1;
        end
        go(75);
        chk("b1_level_after_bounce", 32'(btn1_level), 32'd0);

        // Button 2 long hold then release.
        go(80);
        btn2 = 1'b1;
        expect_ev(87, E_B2P);
`ifdef BTN_LONG_PRESS_EN
        expect_ev(97, E_B2L);
`endif
        go(90);
        chk("b2_level_held", 32'(btn2_level), 32'd1);
        go(107);
        btn2 = 1'b0;
        expect_ev(114, E_B2R);

        // Chord: btn2 accepted while btn1 already held.
        go(120);
        btn1 = 1'b1;
        expect_ev(127, E_B1P);
        go(125);
        btn2 = 1'b1;
        expect_ev(132, E_B2P | E_CH);
`ifdef BTN_LONG_PRESS_EN
        expect_ev(137, E_B1L);
        expect_ev(142, E_B2L);
`endif
        go(150);
        btn1 = 1'b0;
        btn2 = 1'b0;
        expect_ev(157, E_B1R | E_B2R);

        // Both accepted on the same edge.
        go(170);
        btn1 = 1'b1;
        btn2 = 1'b1;
        expect_ev(177, E_B1P | E_B2P | E_CH);
`ifdef BTN_LONG_PRESS_EN
        expect_ev(187, E_B1L | E_B2L);
`endif
        go(195);
        btn1 = 1'b0;
        btn2 = 1'b0;
        expect_ev(202, E_B1R | E_B2R);

        // Reset mid-debounce: press deferred to 6 edges after first rst=0 edge (217).
        go(210);
        btn1 = 1'b1;
        go(214);
        rst = 1'b1;
        go(216);
        rst = 1'b0;
        expect_ev(223, E_B1P);

        // Reset while pressed: no release pulse, press re-accepted after reset.
        go(226);
        rst = 1'b1;
        go(228);
        chk("b1_level_reset_while_held", 32'(btn1_level), 32'd0);
        rst = 1'b0;
        expect_ev(235, E_B1P);
`ifdef BTN_LONG_PRESS_EN
        expect_ev(245, E_B1L);
`endif
        go(236);
        chk("b1_level_reaccepted", 32'(btn1_level), 32'd1);
        go(250);
        btn1 = 1'b0;
        expect_ev(257, E_B1R);

        go(270);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Input-side front end for the LED state controller: takes the two raw push-button pins, synchronises and debounces each, and emits clean single-cycle press, release, long-press and two-button chord events plus debounced levels. Sits between the board button pins and the LED state logic, so the LED controller never sees bounce, metastable or multi-cycle edges.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: cycles an input must stay stable before a press/release is accepted (≥2)
- LONG_CYCLES, 50_000_000: cycles a debounced press must be held, counted after the press event, before a long-press event (≥2)
- CNT_W, 32: width of the per-button cycle counter; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- btn1  in  1  raw button 1 pin, asynchronous, active-high
- btn2  in  1  raw button 2 pin, asynchronous, active-high
- btn1_level, btn2_level  out  1 each  debounced button state (1 = held)
- btn1_press, btn2_press  out  1 each  one-cycle pulse on accepted press
- btn1_release, btn2_release  out  1 each  one-cycle pulse on accepted release
- btn1_long, btn2_long  out  1 each  one-cycle pulse when hold reaches LONG_CYCLES
- chord  out  1  one-cycle pulse when a press is accepted while the other button's level is already 1

## Operation
- Each button: 2-flop synchroniser (s1, s2), then independent FSM with one CNT_W counter and a long_done flag.
- RELEASED: s2=1 → PRESS_PEND, cnt=0.
- PRESS_PEND: s2=0 → RELEASED (bounce discarded, no event). Else cnt==DEBOUNCE_CYCLES-1 → PRESSED, press pulse, level=1, cnt=0, long_done=0; otherwise cnt++.
- PRESSED: s2=0 → REL_PEND, cnt=0. Else if !long_done: cnt==LONG_CYCLES-1 → long pulse, long_done=1; otherwise cnt++. After long_done counter holds.
- REL_PEND: s2=1 → PRESSED (bounce; level stays 1, long timing restarts only if !long_done, cnt=0). Else cnt==DEBOUNCE_CYCLES-1 → RELEASED, release pulse, level=0; otherwise cnt++.
- Counter never wraps: it is cleared on every state entry and compared with ==.
- chord: asserted in the same cycle as the second button's press pulse when the first's level is 1. Both presses accepted on the same edge → chord=1 and both press pulses=1.
- Buttons are fully independent; no priority or mutual exclusion (the LED controller applies its own).

## Timing
- Reset: all outputs 0, FSMs RELEASED, counters 0, synchronisers 0, long_done 0.
- Press latency: raw input first sampled high at edge k, then stable → press pulse and level=1 visible after edge k+2+DEBOUNCE_CYCLES. Release latency identical.
- Long pulse visible LONG_CYCLES edges after the press pulse edge.
- All event outputs are registered and exactly one cycle wide; level outputs registered.
- A button held through reset deassertion produces a press DEBOUNCE_CYCLES+2 cycles after the first edge with rst=0.
- rst mid-debounce or mid-hold: pending event dropped; no release pulse issued for a button pressed at reset time.

## Configuration
- BTN_LONG_PRESS_EN defined: long-press tracking in PRESSED as described; btnN_long active.
- Undefined: long-press counting, long_done and LONG_CYCLES comparison removed; btn1_long, btn2_long tied 0; PRESSED only watches for s2=0. Press/release/chord timing unchanged.

## Structure
- Shared package btn_pkg: FSM state enum (RELEASED, PRESS_PEND, PRESSED, REL_PEND), default DEBOUNCE_CYCLES/LONG_CYCLES constants.
- Sub-module btn_debounce_fsm: synchroniser + FSM + counter for one button, outputs level/press/release/long; instantiated twice. Top adds chord logic only.

## Test plan
- DEBOUNCE_CYCLES=4, LONG_CYCLES=10. btn1 rises before edge 10, held → btn1_press high exactly after edge 16, btn1_level=1 thereafter.
- btn1 high 3 cycles then low (bounce) → no press, level stays 0; repeat toggling every 2 cycles for 20 cycles → no events.
- btn2 held 20 cycles after press → btn2_long one-cycle pulse 10 edges after btn2_press; release → btn2_release 6 edges after first low sample. Without BTN_LONG_PRESS_EN → btn2_long never 1.
- btn1 pressed and accepted, btn2 pressed 5 cycles later → chord coincides with btn2_press; both raised on same edge → btn1_press, btn2_press, chord in one cycle.
- btn1 held, rst asserted 2 cycles at cycle 3 of PRESS_PEND → no press until 6 cycles after rst falls; then press once, no spurious release.
